// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select
// encodings, fetch FSM states and a halfword-alignment helper.
package fetch_unit_pkg;

    localparam int WORD_W = 16;

    // Next-PC select as driven by the control unit on pc_src.
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_RET = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_READY = 2'b10
    } fetch_state_e;

    // Instructions are halfword aligned: bit 0 of every PC is forced low.
    function automatic logic [WORD_W-1:0] align_half(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Circular return-address stack. ptr names the next free slot; the top
// entry sits at ptr-1. A push onto a full stack overwrites the oldest
// entry, which is exactly the slot ptr already points at.
module fetch_unit_return_stack
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_top;
    logic [PW-1:0]     wr_idx;
    logic [CW-1:0]     count;
    logic              do_pop;

    assign ptr_top = ptr - 1'b1;
    assign top     = mem[ptr_top];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop of an empty stack leaves pointer and count untouched.
    assign do_pop  = pop && !empty;
    // Push together with a real pop replaces the top in place.
    assign wr_idx  = do_pop ? ptr_top : ptr;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr <= ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (do_pop && !push) begin
            ptr   <= ptr_top;
            count <= count - 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is deliberately not reset; count==0 already
        // marks every slot invalid, so clearing it would only cost logic.
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// latches the returned word into the IR and commits the next PC
// (sequential, branch, jump or return) when the control unit asks.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_update,
    input  logic [1:0]  pc_src,
    input  logic        is_call,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        ras_overflow,
    output logic        ras_underflow,
    output logic        misaligned
);

    fetch_state_e state;
    fetch_state_e state_next;
    pc_src_e      src;
    logic [15:0]  sel;
    logic [15:0]  ras_top;
    logic         ras_full;
    logic         ras_empty;
    logic         commit;
    logic         ras_push;
    logic         ras_pop;

    assign src         = pc_src_e'(pc_src);
    assign imem_addr   = pc;
    assign pc_plus2    = pc + 16'd2;
    assign instr_valid = (state == ST_READY);
    // pc_update is only meaningful once the IR holds the current instruction.
    assign commit      = pc_update && (state == ST_READY);
    assign ras_push    = commit && is_call;
    assign ras_pop     = commit && (src == PCSRC_RET);

    fetch_unit_return_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_plus2),
        .top      (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: IDLE -> FETCH on request, FETCH -> READY, READY -> IDLE on commit.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:  if (fetch_req) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_READY;
            ST_READY: if (pc_update) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next-PC select; an empty stack on return falls back to RESET_PC.
    always_comb begin
        sel = pc_plus2;
        case (src)
            PCSRC_SEQ: sel = pc_plus2;
            PCSRC_BR:  sel = branch_target;
            PCSRC_JMP: sel = jump_target;
            PCSRC_RET: sel = ras_empty ? RESET_PC : ras_top;
            default:   sel = pc_plus2;
        endcase
    end

    // PC, IR and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= align_half(RESET_PC);
            instr         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                instr <= imem_instr;
            end
            if (commit) begin
                pc <= align_half(sel);
                if (sel[0]) begin
                    misaligned <= 1'b1;
                end
                if (ras_pop && ras_empty) begin
                    ras_underflow <= 1'b1;
                end
                // A push paired with a real pop only replaces the top, so it never overflows.
                if (ras_push && ras_full && !(ras_pop && !ras_empty)) begin
                    ras_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a queue-based behavioural model.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_update;
    logic [1:0]  pc_src;
    logic        is_call;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .pc_update    (pc_update),
        .pc_src       (pc_src),
        .is_call      (is_call),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow),
        .misaligned   (misaligned)
    );

    // Instruction memory contents: fixed word at address 0, a hash elsewhere.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'hB123;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // ---------------- behavioural model ----------------
    // m_phase: 0 waiting for a fetch request, 1 word in flight, 2 word held.
    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_ras[$];
    logic        m_of;
    logic        m_uf;
    logic        m_mis;

    task automatic model_commit();
        logic [15:0] p2;
        logic [15:0] tgt;
        bit          popped;
        p2     = m_pc + 16'd2;
        popped = 0;
        tgt    = p2;
        case (pc_src)
            2'd0: tgt = p2;
            2'd1: tgt = branch_target;
            2'd2: tgt = jump_target;
            default: begin
                if (m_ras.size() == 0) begin
                    tgt  = RESET_PC;
                    m_uf = 1'b1;
                end else begin
                    tgt    = m_ras.pop_back();
                    popped = 1;
                end
            end
        endcase
        if (is_call) begin
            if (!popped && m_ras.size() == RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_of = 1'b1;
            end
            m_ras.push_back(p2);
        end
        if (tgt[0]) m_mis = 1'b1;
        m_pc = tgt & 16'hFFFE;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_phase = 0;
            m_pc    = RESET_PC;
            m_ir    = '0;
            m_ras.delete();
            m_of    = 1'b0;
            m_uf    = 1'b0;
            m_mis   = 1'b0;
        end else begin
            case (m_phase)
                0: if (fetch_req) m_phase = 1;
                1: begin
                    m_ir    = mem_word(m_pc);
                    m_phase = 2;
                end
                default: if (pc_update) begin
                    model_commit();
                    m_phase = 0;
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("pc_plus2", pc_plus2, m_pc + 16'd2);
        check("imem_addr", imem_addr, m_pc);
        check("instr", instr, m_ir);
        check("instr_valid", 16'(instr_valid), 16'(m_phase == 2));
        check("ras_overflow", 16'(ras_overflow), 16'(m_of));
        check("ras_underflow", 16'(ras_underflow), 16'(m_uf));
        check("misaligned", 16'(misaligned), 16'(m_mis));
    endtask

    // One clock edge: advance the model on the current inputs, then compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // From READY: commit the given next-PC, then fetch at the new PC (ends in READY).
    task automatic exec(input logic [1:0] src, input logic call,
                        input logic [15:0] bt, input logic [15:0] jt);
        pc_update     = 1'b1;
        pc_src        = src;
        is_call       = call;
        branch_target = bt;
        jump_target   = jt;
        step();
        pc_update = 1'b0;
        is_call   = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
    endtask

    task automatic fetch_now();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        fetch_req     = 1'b0;
        pc_update     = 1'b0;
        pc_src        = 2'd0;
        is_call       = 1'b0;
        branch_target = '0;
        jump_target   = '0;

        // 1: reset state, then a fetch from address 0.
        step();
        reset = 1'b0;
        check("t1_reset_pc", pc, 16'h0000);
        check("t1_reset_valid", 16'(instr_valid), 16'h0000);
        check("t1_reset_instr", instr, 16'h0000);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("t1_valid_after_1", 16'(instr_valid), 16'h0000);
        step();
        check("t1_instr", instr, 16'hB123);
        check("t1_valid", 16'(instr_valid), 16'h0001);
        check("t1_pc", pc, 16'h0000);
        check("t1_pc_plus2", pc_plus2, 16'h0002);

        // 2: sequential wrap from FFFE to 0000.
        exec(2'd2, 1'b0, 16'h0000, 16'hFFFE);
        check("t2_at_fffe", pc, 16'hFFFE);
        check("t2_plus2_wrap", pc_plus2, 16'h0000);
        exec(2'd0, 1'b0, 16'h0000, 16'h0000);
        check("t2_pc_wrap", pc, 16'h0000);
        check("t2_instr_addr0", instr, 16'hB123);
        check("t2_no_mis", 16'(misaligned), 16'h0000);

        // 3: call from 0004 then return to 0006.
        exec(2'd0, 1'b0, 16'h0000, 16'h0000);
        exec(2'd0, 1'b0, 16'h0000, 16'h0000);
        check("t3_pc_0004", pc, 16'h0004);
        exec(2'd2, 1'b1, 16'h0000, 16'h0020);
        check("t3_call_pc", pc, 16'h0020);
        exec(2'd3, 1'b0, 16'h0000, 16'h0000);
        check("t3_ret_pc", pc, 16'h0006);

        // 4: five calls overflow a 4-deep stack; returns unwind, fifth underflows.
        exec(2'd2, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            exec(2'd2, 1'b1, 16'h0000, 16'(2 * i + 2));
        end
        check("t4_overflow", 16'(ras_overflow), 16'h0001);
        check("t4_no_underflow", 16'(ras_underflow), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            exec(2'd3, 1'b0, 16'h0000, 16'h0000);
            check("t4_ret_pc", pc, 16'(16'h000A - 16'(2 * i)));
        end
        exec(2'd3, 1'b0, 16'h0000, 16'h0000);
        check("t4_underflow_pc", pc, RESET_PC);
        check("t4_underflow", 16'(ras_underflow), 16'h0001);

        // 5: odd branch target, then ignored strobes in FETCH and READY.
        exec(2'd1, 1'b0, 16'h0013, 16'h0000);
        check("t5_pc_0012", pc, 16'h0012);
        check("t5_misaligned", 16'(misaligned), 16'h0001);
        pc_update = 1'b1;
        pc_src    = 2'd0;
        step();
        fetch_req = 1'b1;
        pc_update = 1'b0;
        step();
        fetch_req   = 1'b0;
        pc_update   = 1'b1;
        pc_src      = 2'd2;
        jump_target = 16'h0100;
        step();
        check("t5_fetch_pc_held", pc, 16'h0014);
        check("t5_fetch_valid", 16'(instr_valid), 16'h0001);
        pc_update = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("t5_ready_pc_held", pc, 16'h0014);
        check("t5_ready_instr", instr, mem_word(16'h0014));
        check("t5_ready_valid", 16'(instr_valid), 16'h0001);

        // 6: reset in READY with two stacked return addresses.
        exec(2'd2, 1'b1, 16'h0000, 16'h0040);
        exec(2'd2, 1'b1, 16'h0000, 16'h0080);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_pc", pc, RESET_PC);
        check("t6_instr", instr, 16'h0000);
        check("t6_valid", 16'(instr_valid), 16'h0000);
        check("t6_flags", {13'd0, ras_overflow, ras_underflow, misaligned}, 16'h0000);
        fetch_now();
        exec(2'd3, 1'b0, 16'h0000, 16'h0000);
        check("t6_ras_empty", 16'(ras_underflow), 16'h0001);

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            fetch_req     = $urandom_range(0, 1) == 1;
            pc_update     = $urandom_range(0, 1) == 1;
            pc_src        = 2'($urandom_range(0, 3));
            is_call       = ($urandom_range(0, 2) == 0);
            branch_target = 16'($urandom);
            jump_target   = 16'($urandom);
            step();
        end

        reset     = 1'b0;
        fetch_req = 1'b0;
        pc_update = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
